// File: rtl/hold_gen_pkg.sv
// -----------------------------------------------------------------------------
// hold_gen_pkg
// Shared types and helpers for the level-hold transmitter (hold_pulse_gen).
//   hold_gen_state_e : FSM state encoding (IDLE, HOLD, GAP, DONE)
//   cnt_width()      : width of the shared phase counter, sized so that it
//                      holds max(hold, gap) without wrapping.
// -----------------------------------------------------------------------------
package hold_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } hold_gen_state_e;

  function automatic int cnt_width(input int hold, input int gap);
    int max_len;
    max_len = (hold > gap) ? hold : gap;
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/hold_gen_counter.sv
// -----------------------------------------------------------------------------
// hold_gen_counter
// Phase counter shared by the HOLD and GAP phases of hold_pulse_gen.
// Registered count, combinational terminal-count compare.
// Ports:
//   i_clk     in  1  clock
//   i_rst_n   in  1  reset, synchronous, active-low (count -> 0)
//   clr       in  1  reload count to 0 (has priority over inc)
//   inc       in  1  advance count by one
//   term_val  in  W  terminal count for the current phase
//   cnt       out W  current count
//   at_term   out 1  cnt == term_val
// -----------------------------------------------------------------------------
module hold_gen_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt     = cnt_reg;
  assign at_term = (cnt_reg == term_val);

endmodule

// File: rtl/hold_pulse_gen.sv
// -----------------------------------------------------------------------------
// hold_pulse_gen
// Transmit side of the one-second level-hold link. An accepted start request
// drives o_data high for exactly HOLD_CYCLES clocks, then low for GAP_CYCLES
// clocks, then pulses o_done for one cycle. A transfer can be aborted while
// in HOLD or GAP, which pulses o_aborted instead.
//
// Optional feature (macro HOLD_PULSE_GEN_REPEAT_EN):
//   adds input i_repeat; when high in DONE the FSM restarts HOLD directly,
//   giving back-to-back transfers with no IDLE cycle between them.
//
// Ports:
//   i_clk          in  1  clock
//   i_rst_n        in  1  reset, synchronous, active-low
//   i_start_valid  in  1  start request, held until accepted
//   o_start_ready  out 1  high in IDLE (decoded from state register)
//   i_abort        in  1  terminate a transfer in HOLD/GAP
//   i_repeat       in  1  (HOLD_PULSE_GEN_REPEAT_EN only) restart from DONE
//   o_data         out 1  line output, registered
//   o_busy         out 1  high in HOLD and GAP, registered
//   o_done         out 1  one-cycle pulse on normal completion, registered
//   o_aborted      out 1  one-cycle pulse on abort, registered
// -----------------------------------------------------------------------------
module hold_pulse_gen
  import hold_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_002,
  parameter int GAP_CYCLES  = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start_valid,
  output logic o_start_ready,
  input  logic i_abort,
`ifdef HOLD_PULSE_GEN_REPEAT_EN
  input  logic i_repeat,
`endif
  output logic o_data,
  output logic o_busy,
  output logic o_done,
  output logic o_aborted
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("hold_pulse_gen: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("hold_pulse_gen: GAP_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);

  hold_gen_state_e state_reg, state_next;
  logic data_reg,    data_next;
  logic busy_reg,    busy_next;
  logic done_reg,    done_next;
  logic aborted_reg, aborted_next;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] term_val;
  logic [CNT_W-1:0] cnt_val;
  logic             at_term;

  // One counter serves both timed phases; only the terminal value changes.
  assign term_val = (state_reg == GAP) ? GAP_TERM : HOLD_TERM;

  hold_gen_counter #(
    .W (CNT_W)
  ) u_counter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .term_val (term_val),
    .cnt      (cnt_val),
    .at_term  (at_term)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      data_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

  // Defaults describe "return to idle": counter cleared, all outputs low.
  // Each state only overrides what keeps the transfer going.
  always_comb begin
    state_next   = state_reg;
    data_next    = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    cnt_clr      = 1'b1;
    cnt_inc      = 1'b0;

    case (state_reg)
      IDLE: begin
        // Abort is meaningless here, so start wins when both are present.
        if (i_start_valid) begin
          state_next = HOLD;
          data_next  = 1'b1;
          busy_next  = 1'b1;
        end
      end

      HOLD: begin
        if (i_abort) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else if (at_term) begin
          state_next = GAP;
          busy_next  = 1'b1;
        end else begin
          data_next = 1'b1;
          busy_next = 1'b1;
          cnt_clr   = 1'b0;
          cnt_inc   = 1'b1;
        end
      end

      GAP: begin
        // Abort beats the terminal count, so no done pulse follows an abort.
        if (i_abort) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else if (at_term) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          busy_next = 1'b1;
          cnt_clr   = 1'b0;
          cnt_inc   = 1'b1;
        end
      end

      DONE: begin
`ifdef HOLD_PULSE_GEN_REPEAT_EN
        if (i_repeat) begin
          state_next = HOLD;
          data_next  = 1'b1;
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The counter must never run past the terminal value of the active phase.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (state_reg == HOLD || state_reg == GAP)) begin
      assert (cnt_val <= term_val);
    end
  end

  assign o_start_ready = (state_reg == IDLE);
  assign o_data        = data_reg;
  assign o_busy        = busy_reg;
  assign o_done        = done_reg;
  assign o_aborted     = aborted_reg;

endmodule

// File: tb/tb_hold_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_hold_pulse_gen
// Directed bench for hold_pulse_gen with HOLD_CYCLES=5, GAP_CYCLES=3.
// Stimulus pushes the expected end-of-transfer event (kind, number of o_data
// high cycles, pulse cycle counted from acceptance) into a queue; a monitor
// pops and compares whenever o_done or o_aborted pulses. Cycle n is the
// clock period that follows edge n-1, with acceptance at edge 0.
// -----------------------------------------------------------------------------
module tb_hold_pulse_gen;

  localparam int HOLD = 5;
  localparam int GAP  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start_valid;
  logic start_ready;
  logic abort_in;
`ifdef HOLD_PULSE_GEN_REPEAT_EN
  logic repeat_in;
`endif
  logic data_out;
  logic busy_out;
  logic done_out;
  logic aborted_out;

  always #5 clk = ~clk;

  hold_pulse_gen #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start_valid (start_valid),
    .o_start_ready (start_ready),
    .i_abort       (abort_in),
`ifdef HOLD_PULSE_GEN_REPEAT_EN
    .i_repeat      (repeat_in),
`endif
    .o_data        (data_out),
    .o_busy        (busy_out),
    .o_done        (done_out),
    .o_aborted     (aborted_out)
  );

  typedef struct {
    int kind;   // 0 = done, 1 = aborted
    int highs;  // o_data high cycles in the transfer
    int cyc;    // cycle of the pulse, acceptance at edge 0
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, act, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int kind, input int highs, input int cyc);
    exp_t e;
    e.kind  = kind;
    e.highs = highs;
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  // Raise start, wait (bounded) for ready, let one edge accept it.
  // Returns in cycle 1 of the new transfer.
  task automatic do_start(input bit keep_valid);
    int waited;
    waited = 0;
    start_valid = 1'b1;
    while (start_ready !== 1'b1 && waited < 30) begin
      step(1);
      waited++;
    end
    if (start_ready !== 1'b1) check("start_ready_timeout", 0, 1);
    step(1);
    if (!keep_valid) start_valid = 1'b0;
  endtask

  // Edge counter
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int   acc_edge;
    int   highs;
    exp_t e;
    acc_edge = 0;
    highs    = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (data_out === 1'b1) highs++;
        if (done_out === 1'b1 || aborted_out === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("event_kind",  (aborted_out === 1'b1) ? 1 : 0, e.kind);
            check("event_highs", highs, e.highs);
            check("event_cycle", edge_n - acc_edge + 1, e.cyc);
          end
`ifdef HOLD_PULSE_GEN_REPEAT_EN
          if (done_out === 1'b1 && repeat_in === 1'b1) begin
            acc_edge = edge_n + 1;
            highs    = 0;
          end
`endif
        end
        if (start_valid === 1'b1 && start_ready === 1'b1) begin
          acc_edge = edge_n + 1;
          highs    = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    abort_in    = 1'b0;
`ifdef HOLD_PULSE_GEN_REPEAT_EN
    repeat_in   = 1'b0;
`endif
    step(3);

    // Reset state
    check("rst_data",    int'(data_out),    0);
    check("rst_busy",    int'(busy_out),    0);
    check("rst_done",    int'(done_out),    0);
    check("rst_aborted", int'(aborted_out), 0);
    check("rst_ready",   int'(start_ready), 1);
    rst_n = 1'b1;
    step(2);

    // Normal transfer
    push_exp(0, 5, 9);
    do_start(1'b0);
    check("norm_c1_data",  int'(data_out),    1);
    check("norm_c1_busy",  int'(busy_out),    1);
    check("norm_c1_ready", int'(start_ready), 0);
    step(4);
    check("norm_c5_data",  int'(data_out),    1);
    step(1);
    check("norm_c6_data",  int'(data_out),    0);
    check("norm_c6_busy",  int'(busy_out),    1);
    step(3);
    check("norm_c9_done",  int'(done_out),    1);
    check("norm_c9_busy",  int'(busy_out),    0);
    step(1);
    check("norm_c10_ready", int'(start_ready), 1);
    check("norm_c10_done",  int'(done_out),    0);
    step(1);

    // Abort in HOLD at cycle 3
    push_exp(1, 3, 4);
    do_start(1'b0);
    step(2);
    abort_in = 1'b1;
    step(1);
    abort_in = 1'b0;
    check("abh_c4_data",    int'(data_out),    0);
    check("abh_c4_aborted", int'(aborted_out), 1);
    check("abh_c4_busy",    int'(busy_out),    0);
    check("abh_c4_ready",   int'(start_ready), 1);
    step(1);
    check("abh_c5_aborted", int'(aborted_out), 0);
    step(1);

    // Abort on the GAP terminal cycle: abort wins, no done
    push_exp(1, 5, 9);
    do_start(1'b0);
    step(7);
    abort_in = 1'b1;
    step(1);
    abort_in = 1'b0;
    check("abg_c9_aborted", int'(aborted_out), 1);
    check("abg_c9_done",    int'(done_out),    0);
    step(1);
    check("abg_c10_done",   int'(done_out),    0);
    step(1);

    // Reset mid-transfer at cycle 2: everything clears, no pulses
    do_start(1'b0);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mrst_data",    int'(data_out),    0);
    check("mrst_busy",    int'(busy_out),    0);
    check("mrst_done",    int'(done_out),    0);
    check("mrst_aborted", int'(aborted_out), 0);
    check("mrst_ready",   int'(start_ready), 1);
    step(12);

    // Start held continuously: second acceptance at the end of cycle 10
    push_exp(0, 5, 9);
    push_exp(0, 5, 9);
    do_start(1'b1);
    step(8);
    check("held_c9_done",   int'(done_out),    1);
    check("held_c9_ready",  int'(start_ready), 0);
    step(1);
    check("held_c10_ready", int'(start_ready), 1);
    check("held_c10_data",  int'(data_out),    0);
    step(1);
    start_valid = 1'b0;
    check("held_c11_data",  int'(data_out),    1);
    check("held_c11_busy",  int'(busy_out),    1);
    step(8);
    check("held2_c9_done",  int'(done_out),    1);
    step(2);

    // Start and abort together in IDLE: start is accepted
    push_exp(0, 5, 9);
    abort_in = 1'b1;
    do_start(1'b0);
    abort_in = 1'b0;
    check("sa_c1_data", int'(data_out), 1);
    check("sa_c1_busy", int'(busy_out), 1);
    step(8);
    check("sa_c9_done", int'(done_out), 1);
    step(2);

`ifdef HOLD_PULSE_GEN_REPEAT_EN
    // Repeat: DONE goes straight back to HOLD, ready never rises
    push_exp(0, 5, 9);
    push_exp(0, 5, 9);
    repeat_in = 1'b1;
    do_start(1'b0);
    step(8);
    check("rep_c9_done",   int'(done_out),    1);
    check("rep_c9_ready",  int'(start_ready), 0);
    step(1);
    repeat_in = 1'b0;
    check("rep_c10_ready", int'(start_ready), 0);
    check("rep_c10_data",  int'(data_out),    1);
    check("rep_c10_busy",  int'(busy_out),    1);
    step(8);
    check("rep2_c9_done",  int'(done_out),    1);
    step(1);
    check("rep2_c10_ready", int'(start_ready), 1);
    step(1);
`endif

    step(4);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
